// File: rtl/game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/PAUSE/OVER FSM, step-rate timer, BCD score, over-hold timer.
// All outputs registered (1-cycle latency from inputs). No backpressure. Parameters must stay below 2^26, with 2 <= STEP_MIN <= STEP_INIT.
module game_ctrl #(
  parameter int unsigned STEP_INIT = 12_500_000,
  parameter int unsigned STEP_MIN  = 2_500_000,
  parameter int unsigned STEP_DEC  = 500_000,
  parameter int unsigned OVER_HOLD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       hit_wall,
  input  logic       hit_self,
  input  logic       food_eaten,
  output logic       step_tick,
  output logic       game_clr,
  output logic       the_end,
  output logic       playing,
  output logic       paused,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones
);

  localparam logic [25:0] P_INIT = 26'(STEP_INIT);
  localparam logic [25:0] P_MIN  = 26'(STEP_MIN);
  localparam logic [25:0] P_DEC  = 26'(STEP_DEC);
  localparam logic [25:0] P_HOLD = 26'(OVER_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_OVER} state_t;

  state_t      state;
  logic        start_prev;
  logic        pause_prev;
  logic [25:0] step_cnt;
  logic [25:0] period;
  logic [25:0] hold_cnt;
  logic [25:0] next_period;
  logic        start_edge;
  logic        pause_edge;
  logic        collide;
  logic        launch;

  assign start_edge = key_start & ~start_prev;
  assign pause_edge = key_pause & ~pause_prev;
  assign collide    = hit_wall | hit_self;
  assign launch     = start_edge &
                      ((state == S_IDLE) | ((state == S_OVER) & (hold_cnt == P_HOLD)));

  // Widened compare so period - STEP_DEC can never wrap below the floor.
  always_comb begin
    next_period = P_MIN;
    if ({1'b0, period} >= ({1'b0, P_MIN} + {1'b0, P_DEC}))
      next_period = period - P_DEC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      step_cnt   <= '0;
      period     <= P_INIT;
      hold_cnt   <= '0;
      step_tick  <= 1'b0;
      game_clr   <= 1'b0;
      the_end    <= 1'b0;
      playing    <= 1'b0;
      paused     <= 1'b0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
    end else begin
      start_prev <= key_start;
      pause_prev <= key_pause;
      step_tick  <= 1'b0;
      game_clr   <= 1'b0;
      if (launch) begin
        state      <= S_PLAY;
        game_clr   <= 1'b1;
        playing    <= 1'b1;
        paused     <= 1'b0;
        the_end    <= 1'b0;
        score_tens <= 4'd0;
        score_ones <= 4'd0;
        step_cnt   <= '0;
        period     <= P_INIT;
      end else begin
        case (state)
          S_PLAY: begin
            if (collide) begin
              state    <= S_OVER;
              playing  <= 1'b0;
              the_end  <= 1'b1;
              hold_cnt <= '0;
            end else begin
              // A pause edge freezes the count where it stands, without ticking.
              if (pause_edge) begin
                state   <= S_PAUSE;
                playing <= 1'b0;
                paused  <= 1'b1;
              end else if (step_cnt >= period - 26'd1) begin
                step_tick <= 1'b1;
                step_cnt  <= '0;
              end else begin
                step_cnt <= step_cnt + 26'd1;
              end
              if (food_eaten) begin
                if (score_ones != 4'd9) begin
                  score_ones <= score_ones + 4'd1;
                end else if (score_tens != 4'd9) begin
                  score_ones <= 4'd0;
                  score_tens <= score_tens + 4'd1;
                end
                period <= next_period;
              end
            end
          end
          S_PAUSE: begin
            if (start_edge | pause_edge) begin
              state   <= S_PLAY;
              playing <= 1'b1;
              paused  <= 1'b0;
            end
          end
          S_OVER: begin
            if (hold_cnt < P_HOLD)
              hold_cnt <= hold_cnt + 26'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios then random play, all checked against an integer-level game model.
module tb_game_ctrl;

  localparam int SI = 10;
  localparam int SM = 4;
  localparam int SD = 3;
  localparam int OH = 20;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start = 1'b0;
  logic       key_pause = 1'b0;
  logic       hit_wall = 1'b0;
  logic       hit_self = 1'b0;
  logic       food_eaten = 1'b0;
  logic       step_tick;
  logic       game_clr;
  logic       the_end;
  logic       playing;
  logic       paused;
  logic [3:0] score_tens;
  logic [3:0] score_ones;

  game_ctrl #(
    .STEP_INIT(SI),
    .STEP_MIN (SM),
    .STEP_DEC (SD),
    .OVER_HOLD(OH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_pause (key_pause),
    .hit_wall  (hit_wall),
    .hit_self  (hit_self),
    .food_eaten(food_eaten),
    .step_tick (step_tick),
    .game_clr  (game_clr),
    .the_end   (the_end),
    .playing   (playing),
    .paused    (paused),
    .score_tens(score_tens),
    .score_ones(score_ones)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ticks = 0;

  // Game model: plain integers, score kept as 0..99.
  int m_mode = M_IDLE;
  int m_score = 0;
  int m_period = SI;
  int m_cnt = 0;
  int m_hold = 0;
  bit m_ps = 1'b1;
  bit m_pp = 1'b1;
  bit m_tick = 1'b0;
  bit m_clr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    m_mode   = M_PLAY;
    m_clr    = 1'b1;
    m_score  = 0;
    m_cnt    = 0;
    m_period = SI;
  endtask

  task automatic model_update();
    bit se;
    bit pe;
    if (!rst_n) begin
      m_mode = M_IDLE; m_score = 0; m_period = SI; m_cnt = 0; m_hold = 0;
      m_ps = 1'b1; m_pp = 1'b1; m_tick = 1'b0; m_clr = 1'b0;
      return;
    end
    se = key_start && !m_ps;
    pe = key_pause && !m_pp;
    m_ps = key_start;
    m_pp = key_pause;
    m_tick = 1'b0;
    m_clr = 1'b0;
    case (m_mode)
      M_IDLE: if (se) model_start();
      M_PLAY: begin
        if (hit_wall || hit_self) begin
          m_mode = M_OVER;
          m_hold = 0;
        end else begin
          if (pe) m_mode = M_PAUSE;
          else if (m_cnt + 1 >= m_period) begin m_tick = 1'b1; m_cnt = 0; end
          else m_cnt = m_cnt + 1;
          if (food_eaten) begin
            if (m_score < 99) m_score = m_score + 1;
            m_period = (m_period - SD < SM) ? SM : m_period - SD;
          end
        end
      end
      M_PAUSE: if (se || pe) m_mode = M_PLAY;
      default: begin
        if (se && m_hold >= OH) model_start();
        else if (m_hold < OH) m_hold = m_hold + 1;
      end
    endcase
  endtask

  task automatic check_model();
    chk("playing", playing, m_mode == M_PLAY);
    chk("paused", paused, m_mode == M_PAUSE);
    chk("the_end", the_end, m_mode == M_OVER);
    chk("step_tick", step_tick, m_tick);
    chk("game_clr", game_clr, m_clr);
    chk("score_tens", score_tens, m_score / 10);
    chk("score_ones", score_ones, m_score % 10);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
    if (step_tick === 1'b1) ticks++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Cycles until the next step_tick; 999 when none shows up within the budget.
  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n = 999;
    for (int i = 1; i <= 30; i++) begin
      if (!seen) begin
        step();
        if (step_tick === 1'b1) begin
          n = i;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      food_eaten = 1'b1; step();
      food_eaten = 1'b0; step();
    end
  endtask

  initial begin
    int gap;

    // Key held through reset release must not start a game.
    key_start = 1'b1;
    steps(3);
    chk("rst_playing", playing, 0);
    chk("rst_score", {score_tens, score_ones}, 0);
    rst_n = 1'b1;
    steps(5);
    chk("held_key_idle", playing, 0);
    key_start = 1'b0; step();
    key_start = 1'b1; step();
    key_start = 1'b0;
    chk("start_clr", game_clr, 1);
    chk("start_playing", playing, 1);

    ticks = 0;
    steps(30);
    chk("tick_every_10", ticks, 3);

    feed(3);
    chk("food3_ones", score_ones, 3);
    wait_tick(gap);
    wait_tick(gap);
    chk("period_floor", gap, 4);

    feed(105);
    chk("sat_tens", score_tens, 9);
    chk("sat_ones", score_ones, 9);

    hit_wall = 1'b1; step(); hit_wall = 1'b0;
    chk("wall_over", the_end, 1);
    steps(25);
    key_start = 1'b1; step(); key_start = 1'b0;
    chk("restart_clr", game_clr, 1);
    chk("restart_score", {score_tens, score_ones}, 0);

    feed(5);
    hit_self = 1'b1; food_eaten = 1'b1; step();
    hit_self = 1'b0; food_eaten = 1'b0;
    chk("self_over", the_end, 1);
    chk("over_score", score_ones, 5);
    ticks = 0;
    steps(5);
    key_start = 1'b1; step(); key_start = 1'b0;
    chk("early_start_ignored", playing, 0);
    steps(20);
    chk("over_no_ticks", ticks, 0);
    chk("over_score_kept", score_ones, 5);
    key_start = 1'b1; step(); key_start = 1'b0;
    chk("over_restart_clr", game_clr, 1);
    chk("over_restart_play", playing, 1);
    chk("over_restart_score", score_ones, 0);

    steps(6);
    key_pause = 1'b1; step(); key_pause = 1'b0;
    chk("pause_entered", paused, 1);
    ticks = 0;
    food_eaten = 1'b1; hit_wall = 1'b1; step();
    food_eaten = 1'b0; hit_wall = 1'b0;
    steps(49);
    chk("pause_no_ticks", ticks, 0);
    chk("pause_ignores_food", score_ones, 0);
    key_pause = 1'b1; step(); key_pause = 1'b0;
    chk("resume_play", playing, 1);
    wait_tick(gap);
    chk("resume_gap", gap, 4);

    // Asynchronous reset mid-game.
    feed(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_playing", playing, 0);
    chk("async_rst_score", score_ones, 0);
    chk("async_rst_tick", step_tick, 0);
    chk("async_rst_clr", game_clr, 0);
    steps(2);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) key_start = ~key_start;
      if ($urandom_range(0, 7) == 0) key_pause = ~key_pause;
      hit_wall   = ($urandom_range(0, 59) == 0);
      hit_self   = ($urandom_range(0, 59) == 0);
      food_eaten = ($urandom_range(0, 5) == 0);
      rst_n      = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter STEP_INIT, default 12_500_000, meaning clock cycles per snake step at score 00.
REQ-002 SHALL have parameter STEP_MIN, default 2_500_000, meaning the floor on the step period.
REQ-003 SHALL have parameter STEP_DEC, default 500_000, meaning the step-period reduction per food eaten.
REQ-004 SHALL have parameter OVER_HOLD, default 50_000_000, meaning the minimum number of cycles in OVER before a restart is accepted.
REQ-005 SHALL constrain all parameters to be less than 2^26, with STEP_MIN >= 2 and STEP_MIN <= STEP_INIT.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port key_start, input, 1 bit: synchronous debounced level, active high.
REQ-009 SHALL have port key_pause, input, 1 bit: synchronous debounced level, active high.
REQ-010 SHALL have port hit_wall, input, 1 bit: snake head at border, level.
REQ-011 SHALL have port hit_self, input, 1 bit: snake head on body, level.
REQ-012 SHALL have port food_eaten, input, 1 bit: one-cycle pulse per food consumed.
REQ-013 SHALL have port step_tick, output, 1 bit: one-cycle pulse that advances the snake one cell.
REQ-014 SHALL have port game_clr, output, 1 bit: one-cycle pulse that reinitialises snake body and food.
REQ-015 SHALL have port the_end, output, 1 bit: game-over flag, consumed by the colour merge stage.
REQ-016 SHALL have port playing, output, 1 bit: state is PLAY.
REQ-017 SHALL have port paused, output, 1 bit: state is PAUSE.
REQ-018 SHALL have port score_tens, output, 4 bits: BCD tens digit.
REQ-019 SHALL have port score_ones, output, 4 bits: BCD ones digit.

Function
REQ-020 SHALL detect key events internally as rising edges of key_start and key_pause, using one registered previous-value bit per key.
REQ-021 SHALL implement FSM states IDLE, PLAY, PAUSE, OVER, with all outputs registered.
REQ-022 SHALL, in IDLE on a start edge, enter PLAY, pulse game_clr for exactly the first PLAY cycle, clear score to 00, clear the step counter, and load period=STEP_INIT.
REQ-023 SHALL, in PLAY, increment a 26-bit step counter each cycle; when counter >= period-1, pulse step_tick and reset counter to 0.
REQ-024 SHALL, in PLAY when (hit_wall|hit_self)=1, enter OVER next cycle with no step_tick that cycle; collision has top priority.
REQ-025 SHALL, in PLAY when food_eaten=1 and no collision, increment score in BCD (09->10), saturating at 99, and set period=max(period-STEP_DEC, STEP_MIN) with no underflow.
REQ-026 SHALL, in PLAY on a pause edge with no collision, enter PAUSE; a food_eaten pulse in the same cycle is still counted.
REQ-027 SHALL, in PAUSE, freeze the step counter and emit no step_tick.
REQ-028 SHALL, in PAUSE, ignore collision and food_eaten.
REQ-029 SHALL, in PAUSE, return to PLAY on a pause or start edge, resuming from the frozen count.
REQ-030 SHALL, in OVER, hold the_end=1 and retain the score.
REQ-031 SHALL, in OVER, count hold cycles from 0 up to OVER_HOLD, saturating there.
REQ-032 SHALL, in OVER, ignore start edges while hold < OVER_HOLD.
REQ-033 SHALL, in OVER once hold has reached OVER_HOLD, act on a start edge exactly as in REQ-022.
REQ-034 SHALL ignore food_eaten outside PLAY.
REQ-035 SHALL drive the_end=0 in IDLE, PLAY and PAUSE.

Reset
REQ-036 SHALL, on rst_n=0, immediately enter IDLE, drive all outputs to 0 and score to 00, set period=STEP_INIT, and clear the step and hold counters.
REQ-037 SHALL reset both key previous-value registers to 1, so a key held through reset release produces no edge.
REQ-038 SHALL, on reset asserted mid-game (any state), abort without emitting a game_clr or step_tick pulse.

Verification (STEP_INIT=10, STEP_MIN=4, STEP_DEC=3, OVER_HOLD=20)
REQ-039 SHALL be covered by this scenario: release reset, start edge -> game_clr high 1 cycle, playing=1, step_tick every 10 cycles.
REQ-040 SHALL be covered by this scenario: three food pulses in PLAY -> score 03, period 10->7->4->4.
REQ-041 SHALL be covered by this scenario: 105 food pulses -> score 99 held, no wrap.
REQ-042 SHALL be covered by this scenario: hit_self with food_eaten in the same cycle at score 05 -> OVER, the_end=1, score 05, no ticks; start at hold cycle 5 ignored; start after 20 cycles -> PLAY, score 00, game_clr pulse.
REQ-043 SHALL be covered by this scenario: pause edge at counter=6, wait 50 cycles, pause edge -> no ticks while paused; first tick 4 cycles after resume.
REQ-044 SHALL be covered by this scenario: key_start high through reset release -> remains IDLE until key released and pressed again.
